// File: rtl/stream_mux_rr.sv
// N-channel registered valid/ready stream multiplexer with round-robin or fixed-select
// arbitration; grants are held for the whole packet until the granted channel's last beat.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready,
  output logic                  locked
);

  localparam int unsigned NCH  = N_CH;
  localparam int unsigned NPAD = 2 ** SEL_W;
  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] hch_q, hch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             lock_mode_q, lock_mode_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic             ld;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] idx;
  logic             xfer;
  logic             mode_eff;
  logic [WIDTH-1:0] grant_data;
  logic [NPAD-1:0]  valid_pad;
  logic [NPAD-1:0]  last_pad;

  // Padding to the full index space lets sel/grant index directly without range faults.
  assign valid_pad = NPAD'(in_valid);
  assign last_pad  = NPAD'(in_last);
  assign ld        = !out_valid_q || out_ready;
  assign mode_eff  = (state_q == LOCKED) ? lock_mode_q : mode;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant     = hch_q;
    end else if (mode) begin
      if ({1'b0, sel} < N_CH_W) begin
        if (valid_pad[sel]) begin
          grant_vld = 1'b1;
          grant     = sel;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NCH; i++) begin
        idx = SEL_W'((32'(ptr_q) + i) % NCH);
        if (!grant_vld && valid_pad[idx]) begin
          grant_vld = 1'b1;
          grant     = idx;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant == SEL_W'(k)) grant_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      in_ready[k] = !rst && ld && grant_vld && (grant == SEL_W'(k));
    end
  end

  assign xfer = ld && grant_vld && valid_pad[grant];

  always_comb begin
    state_d     = state_q;
    hch_d       = hch_q;
    ptr_d       = ptr_q;
    lock_mode_d = lock_mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (ld) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_last_d = last_pad[grant];
        out_sel_d  = grant;
        if (last_pad[grant]) begin
          state_d = IDLE;
          // A packet started in round-robin mode advances the pointer even if mode flipped meanwhile.
          if (!mode_eff) ptr_d = grant;
        end else begin
          state_d = LOCKED;
          if (state_q == IDLE) begin
            hch_d       = grant;
            lock_mode_d = mode;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hch_q       <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
      lock_mode_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      hch_q       <= hch_d;
      ptr_q       <= ptr_d;
      lock_mode_q <= lock_mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: a default 4-channel build plus a
// 5-channel/3-bit-select build for out-of-range select handling.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready, locked;
  logic [1:0]  out_sel;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5, out_sel5;
  logic [7:0]  out_data5;
  logic        out_valid5, out_last5, locked5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .SEL_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready), .locked(locked)
  );

  stream_mux_rr #(.N_CH(5), .WIDTH(8), .SEL_W(3)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_last(5'h1f),
    .in_ready(in_ready5), .mode(1'b1), .sel(sel5), .out_data(out_data5),
    .out_valid(out_valid5), .out_last(out_last5), .out_sel(out_sel5),
    .out_ready(1'b1), .locked(locked5)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    in_data[k*8 +: 8] = v;
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
    in_valid = 4'hf; in_last = 4'hf;
    for (int k = 0; k < 4; k++) set_ch(k, 8'(8'h10 + k));
    in_data5 = {8'h44, 8'h43, 8'h42, 8'h41, 8'h40}; in_valid5 = '0; sel5 = 3'd7;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_first_ready", 32'(in_ready), 32'h1);

    // Round-robin over single-beat packets
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(8'h10 + i % 4));
    end

    // Packet hold: ch1 3-beat packet vs continuously valid ch2
    in_valid = 4'b0110; in_last = 4'b0100;
    set_ch(1, 8'ha1); set_ch(2, 8'hb0);
    #1 chk("pkt_ready_a1", 32'(in_ready), 32'h2);
    tick;
    chk("pkt_data_a1", 32'(out_data), 32'ha1);
    chk("pkt_locked_a1", 32'(locked), 1);
    set_ch(1, 8'ha2);
    #1 chk("pkt_ready_a2", 32'(in_ready), 32'h2);
    tick;
    chk("pkt_data_a2", 32'(out_data), 32'ha2);
    chk("pkt_locked_a2", 32'(locked), 1);
    chk("pkt_last_a2", 32'(out_last), 0);
    set_ch(1, 8'ha3); in_last = 4'b0110;
    #1 chk("pkt_ready_a3", 32'(in_ready), 32'h2);
    tick;
    chk("pkt_data_a3", 32'(out_data), 32'ha3);
    chk("pkt_last_a3", 32'(out_last), 1);
    chk("pkt_unlocked", 32'(locked), 0);
    in_valid = 4'b0100;
    #1 chk("pkt_ready_b0", 32'(in_ready), 32'h4);
    tick;
    chk("pkt_data_b0", 32'(out_data), 32'hb0);
    chk("pkt_sel_b0", 32'(out_sel), 2);
    in_valid = 4'b0000;
    tick;
    chk("drain_valid", 32'(out_valid), 0);

    // Backpressure
    in_valid = 4'b0001; in_last = 4'b0001; set_ch(0, 8'h5a);
    tick;
    chk("bp_data0", 32'(out_data), 32'h5a);
    out_ready = 1'b0; set_ch(0, 8'h5b);
    #1 chk("bp_ready0", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_data", 32'(out_data), 32'h5a);
      chk("bp_hold_sel", 32'(out_sel), 0);
      chk("bp_hold_last", 32'(out_last), 1);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick;
    chk("bp_next_data", 32'(out_data), 32'h5b);
    chk("bp_next_valid", 32'(out_valid), 1);
    in_valid = 4'b0000;
    tick;
    chk("bp_no_dup", 32'(out_valid), 0);

    // Fixed select
    mode = 1'b1; sel = 2'd2; in_valid = 4'b0101; in_last = 4'b0101;
    set_ch(0, 8'h70); set_ch(2, 8'h72);
    #1 chk("fix_ready", 32'(in_ready), 32'h4);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("fix_sel", 32'(out_sel), 2);
      chk("fix_data", 32'(out_data), 32'h72);
    end
    sel = 2'd3; sel5 = 3'd7; in_valid5 = 5'h1f;
    #1 chk("fix_noval_ready", 32'(in_ready), 0);
    chk("oor7_ready", 32'(in_ready5), 0);
    tick;
    chk("fix_noval_valid", 32'(out_valid), 0);
    chk("oor7_valid", 32'(out_valid5), 0);
    sel5 = 3'd5;
    #1 chk("oor5_ready", 32'(in_ready5), 0);
    sel5 = 3'd4;
    #1 chk("sel4_ready", 32'(in_ready5), 32'h10);
    tick;
    chk("sel4_valid", 32'(out_valid5), 1);
    chk("sel4_sel", 32'(out_sel5), 4);
    chk("sel4_data", 32'(out_data5), 32'h44);
    in_valid5 = '0;

    // Mode switch while locked
    mode = 1'b0; in_valid = 4'b1000; in_last = 4'b0000; set_ch(3, 8'hc1);
    #1 chk("ms_ready_c1", 32'(in_ready), 32'h8);
    tick;
    chk("ms_data_c1", 32'(out_data), 32'hc1);
    chk("ms_locked", 32'(locked), 1);
    mode = 1'b1; sel = 2'd0; in_valid = 4'b1001; in_last = 4'b1001;
    set_ch(0, 8'hd0); set_ch(3, 8'hc2);
    #1 chk("ms_ready_held", 32'(in_ready), 32'h8);
    tick;
    chk("ms_data_c2", 32'(out_data), 32'hc2);
    chk("ms_unlocked", 32'(locked), 0);
    set_ch(3, 8'hc3);
    #1 chk("ms_ready_sel", 32'(in_ready), 32'h1);
    tick;
    chk("ms_data_d0", 32'(out_data), 32'hd0);
    chk("ms_sel_d0", 32'(out_sel), 0);

    // Reset mid-packet
    mode = 1'b0; in_valid = 4'b0010; in_last = 4'b0000; set_ch(1, 8'he1);
    #1 chk("rp_ready", 32'(in_ready), 32'h2);
    tick;
    chk("rp_locked", 32'(locked), 1);
    chk("rp_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("rp_async_valid", 32'(out_valid), 0);
    chk("rp_async_locked", 32'(locked), 0);
    chk("rp_async_ready", 32'(in_ready), 0);
    in_valid = 4'hf; in_last = 4'hf;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rp_prio_ready", 32'(in_ready), 32'h1);
    tick;
    chk("rp_prio_sel", 32'(out_sel), 0);
    chk("rp_prio_valid", 32'(out_valid), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel streaming multiplexer: the registered, handshaked successor to the combinational 4:1 select mux.
- Merges N_CH valid/ready input streams onto one registered output stream.
- Two selection modes: round-robin arbitration, or fixed external select.
- Packet-aware: once a channel is granted, the grant is held until that channel's last beat transfers.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data bits per channel.
- SEL_W, 2, select/index width; must satisfy 2^SEL_W >= N_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag.
- in_ready  output  N_CH  per-channel ready.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode=1.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output valid.
- out_last  output  1  registered last flag.
- out_sel  output  SEL_W  index of the channel that sourced the current output beat.
- out_ready  input  1  downstream ready.
- locked  output  1  high while a packet is in progress.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_last=0, out_sel=0, locked=0.
  - Round-robin pointer ptr=N_CH-1, so channel 0 has first priority.
  - in_ready is all zero while rst=1.
- Load enable: ld = !out_valid || out_ready.
- Grant calculation (combinational):
  - IDLE (locked=0), mode=0: grant goes to the first k with in_valid[k]=1, searching ptr+1, ptr+2, ... with wrap modulo N_CH.
  - IDLE, mode=1: grant = sel if sel < N_CH and in_valid[sel]=1; otherwise no grant.
  - LOCKED: grant = held channel hch, regardless of mode and sel.
- Ready: in_ready[k] = ld && (k == grant). At most one bit is set; in_ready must not depend on out_valid of the same cycle except through ld.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - Next edge: out_data <= in_data[g], out_last <= in_last[g], out_sel <= g, out_valid <= 1.
  - Latency is 1 cycle; sustained throughput is 1 beat/cycle while out_ready=1.
- Hold: if ld=1 and there is no transfer, out_valid <= 0 on the next edge. If ld=0, all output registers hold (stable under backpressure).
- State machine (IDLE/LOCKED, reflected on the locked output):
  - IDLE -> LOCKED: transfer with in_last=0; hch <= g.
  - LOCKED -> LOCKED: transfer with in_last=0; no change.
  - LOCKED -> IDLE: transfer with in_last=1.
  - IDLE -> IDLE: transfer with in_last=1 (single-beat packet).
- Pointer update: ptr <= g on every transfer with in_last=1, and only in mode 0. Mode 1 leaves ptr unchanged.
- Mode/sel changes while LOCKED are ignored until the return to IDLE. They take effect in the first IDLE cycle.
- A held channel that drops in_valid mid-packet stalls the mux; no other channel is granted.
- Reset mid-packet: returns immediately to IDLE. Any in-flight output beat is discarded (out_valid=0).
- With in_valid all zero, the mux stays idle with out_valid=0 after the final beat drains.
- Undefined or out-of-range sel never produces a grant and never causes an X on in_ready.

Test Plan:
1. Reset, then all 4 channels valid with single-beat packets (last=1, data=8'h10+k), out_ready=1, mode=0 -> out_sel sequence 0,1,2,3,0,...; out_data 10,11,12,13,10; first out_valid one cycle after the first transfer.
2. Ch1 sends 3-beat packet A1,A2,A3 (last on A3) while ch2 is continuously valid with B0 -> output A1,A2,A3,B0; locked=1 from the cycle after A1 to the cycle after A3; in_ready[2]=0 throughout.
3. Backpressure: out_ready=0 for 3 cycles with out_valid=1, out_data=8'h5A -> out_data/out_sel/out_last stable, in_ready all 0; out_ready=1 -> next beat follows with no loss or duplication.
4. mode=1, sel=2, ch2 and ch0 valid -> only ch2 is granted. sel=3'h7 in a N_CH=5, SEL_W=3 build -> no grant, out_valid drops to 0.
5. mode switched 0->1 during a locked ch3 packet -> the remainder of the ch3 packet completes; the sel channel is granted in the first IDLE cycle.
6. rst pulsed while locked=1 and out_valid=1 -> out_valid, locked, and in_ready go to 0 asynchronously; after release, ch0 has first priority.
